// File: rtl/piso_sched_pkg.sv
// Shared FSM encoding and default parameter constants for the PISO transmit scheduler.
package piso_sched_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/piso_shift_unit.sv
// Load / shift-right register with zero fill; bit0 is the serial tap.
module piso_shift_unit
    import piso_sched_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit0
);

    logic [WIDTH-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = din;
        end else if (shift) begin
            sreg_d = sreg_q >> 1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign bit0 = sreg_q[0];

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler that grants one requester at a time and serialises its
// word LSB first, followed by a one-cycle gap.
module piso_tx_sched
    import piso_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       sout,
    output logic                       sout_valid,
    output logic                       frame_start,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] gid_q, gid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sout_valid_q, sout_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] grant_c;
    logic [IDX_W-1:0] win_idx_c;
    logic [WIDTH-1:0] win_data_c;
    logic             load_c;
    logic             shift_c;
    logic             bit0;

    // Rotate so the search starts after last, take lowest set bit, rotate back.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0]   start;
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [N_REQ-1:0]   pick;
        start = (last == IDX_W'(N_REQ - 1)) ? '0 : last + IDX_W'(1);
        dbl   = {valid, valid} >> start;
        rot   = dbl[N_REQ-1:0];
        pick  = rot & (~rot + N_REQ'(1));
        dbl   = {pick, pick} << start;
        return dbl[2*N_REQ-1:N_REQ];
    endfunction

    always_comb begin
        grant_c   = rr_pick(req_valid, last_q);
        win_idx_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                win_idx_c = win_idx_c | IDX_W'(i);
            end
        end
        win_data_c = req_data[win_idx_c*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gid_d     = gid_q;
        cnt_d     = cnt_q;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (!rst && (|req_valid)) begin
                    req_ready = grant_c;
                    load_c    = 1'b1;
                    last_d    = win_idx_c;
                    gid_d     = win_idx_c;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        sout_valid_d  = (state_d == ST_SHIFT);
        frame_start_d = load_c;
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_q        <= IDX_W'(N_REQ - 1);
            gid_q         <= '0;
            cnt_q         <= '0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            gid_q         <= gid_d;
            cnt_q         <= cnt_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    piso_shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clock (clock),
        .rst   (rst),
        .load  (load_c),
        .shift (shift_c),
        .din   (win_data_c),
        .bit0  (bit0)
    );

    assign sout        = bit0;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign grant_id    = gid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Bench for piso_tx_sched: directed scenarios plus random traffic against a frame-level model.
module tb_piso_tx_sched;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic            clock = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            sout;
    logic            sout_valid;
    logic            frame_start;
    logic [IW-1:0]   grant_id;
    logic            busy;

    piso_tx_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clock       (clock),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .frame_start (frame_start),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: phase 0 idle, 1..W carries bit phase-1, W+1 is the gap.
    int          m_phase = 0;
    logic [W-1:0] m_word = '0;
    int          m_gid   = 0;
    int          m_last  = N - 1;
    bit          m_on    = 1'b0;

    logic obs_sout, obs_sv, obs_busy;
    int   gq_id[$];
    int   gq_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        int           win;
        logic [N-1:0] exp_rdy;
        logic         exp_sout;
        @(negedge clock);
        win = -1;
        if (!rst && m_phase == 0) win = pick(req_valid, m_last);
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        exp_sout = 1'b0;
        if (m_phase >= 1 && m_phase <= W) exp_sout = m_word[m_phase-1];
        obs_sout = sout;
        obs_sv   = sout_valid;
        obs_busy = busy;
        if (m_on) begin
            chk("req_ready",   32'(req_ready),   32'(exp_rdy));
            chk("sout",        32'(sout),        32'(exp_sout));
            chk("sout_valid",  32'(sout_valid),  32'(m_phase >= 1 && m_phase <= W));
            chk("frame_start", 32'(frame_start), 32'(m_phase == 1));
            chk("busy",        32'(busy),        32'(m_phase != 0));
            chk("grant_id",    32'(grant_id),    32'(m_gid));
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                gq_id.push_back(i);
                gq_cyc.push_back(cyc);
            end
        end
        @(posedge clock);
        if (rst) begin
            m_phase = 0;
            m_gid   = 0;
            m_last  = N - 1;
            m_on    = 1'b1;
        end else if (m_phase == 0) begin
            if (win >= 0) begin
                m_word  = req_data[win*W +: W];
                m_gid   = win;
                m_last  = win;
                m_phase = 1;
            end
        end else if (m_phase == W + 1) begin
            m_phase = 0;
        end else begin
            m_phase++;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        repeat (W + 3) tick();
    endtask

    initial begin
        int           exp_ids[5];
        logic [W-1:0] got;
        int           n_before;
        exp_ids   = '{0, 1, 2, 3, 0};
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Single requester 0, word 1011
        gq_id.delete(); gq_cyc.delete();
        req_data[0 +: W] = 4'b1011;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        got = '0;
        for (int b = 0; b < W; b++) begin
            tick();
            got[b] = obs_sout;
        end
        chk("s032_word", 32'(got), 32'(4'b1011));
        tick();
        chk("s032_gap_busy", 32'(obs_busy), 32'(1'b1));
        chk("s032_gap_sv",   32'(obs_sv),   32'(1'b0));
        chk("s032_ngrant",   32'(gq_id.size()), 32'(1));
        if (gq_id.size() == 1) chk("s032_gid", 32'(gq_id[0]), 32'(0));
        drain();

        // All four valid: round robin from requester 0 with 6-cycle spacing
        do_reset();
        gq_id.delete(); gq_cyc.delete();
        req_data  = {4'h8, 4'h4, 4'h2, 4'h1};
        req_valid = 4'b1111;
        for (int t = 0; t < 40 && gq_id.size() < 5; t++) tick();
        req_valid = '0;
        chk("s033_ngrant", 32'(gq_id.size()), 32'(5));
        if (gq_id.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("s033_order", 32'(gq_id[i]), 32'(exp_ids[i]));
            for (int i = 1; i < 5; i++) chk("s033_spacing", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'(W + 2));
        end
        drain();

        // Requester 2 alone for 20 cycles
        do_reset();
        gq_id.delete(); gq_cyc.delete();
        req_data[2*W +: W] = 4'h6;
        req_valid = 4'b0100;
        repeat (20) tick();
        req_valid = '0;
        chk("s034_ngrant", 32'(gq_id.size()), 32'(4));
        if (gq_id.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("s034_cycle", 32'(gq_cyc[i] - gq_cyc[0]), 32'(6 * i));
        end
        drain();

        // Data changed right after the handshake
        req_data[2*W +: W] = 4'hA;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        req_data[2*W +: W] = 4'h5;
        got = '0;
        for (int b = 0; b < W; b++) begin
            tick();
            got[b] = obs_sout;
        end
        chk("s035_word", 32'(got), 32'(4'hA));
        drain();

        // Reset on the second shift cycle aborts the frame
        req_data[0 +: W] = 4'hF;
        req_valid = 4'b0001;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gq_id.delete(); gq_cyc.delete();
        req_valid = 4'b1111;
        tick();
        chk("s036_sv",   32'(obs_sv),   32'(1'b0));
        chk("s036_busy", 32'(obs_busy), 32'(1'b0));
        chk("s036_ngrant", 32'(gq_id.size()), 32'(1));
        if (gq_id.size() == 1) chk("s036_gid", 32'(gq_id[0]), 32'(0));
        drain();

        // One-cycle pulse in IDLE is granted; pulse during SHIFT is not
        gq_id.delete(); gq_cyc.delete();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        chk("s037_ngrant", 32'(gq_id.size()), 32'(1));
        if (gq_id.size() == 1) chk("s037_gid", 32'(gq_id[0]), 32'(2));
        n_before = gq_id.size();
        tick();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        drain();
        chk("s037_nogrant", 32'(gq_id.size()), 32'(n_before));

        // Random traffic with occasional resets
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) req_valid = N'($urandom);
            if ($urandom_range(0, 2) == 0) req_data = (N*W)'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
